// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (parity/stop encodings, oversampling, status bit positions)
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2} parity_e;
    typedef enum logic [0:0] {STOP_1 = 1'b0, STOP_2 = 1'b1} stop_e;
    localparam int SAMPLE_RATE   = 16;
    localparam int STS_W         = 2;
    localparam int STS_OVERFLOW  = 0;
    localparam int STS_BAD_FRAME = 1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic first-word-fall-through FIFO; caller guarantees no push when full without pop and no pop when empty
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    // advance pointers and track occupancy; reset empties the FIFO
    always_comb begin
        wr_ptr_d = rst ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rst ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = rst ? '0 : (push & ~pop) ? level_q + (AW+1)'(1) : (pop & ~push) ? level_q - (AW+1)'(1) : level_q;
    end
    // pointer and level registers
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
    end
    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind uart_rx with drop, sticky status and optional idle timeout (UART_RX_FIFO_TIMEOUT_EN)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       rx_dout,
    input  logic                   rx_valid,
    input  logic                   parity_err,
    input  logic                   cfg_drop_bad,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_perr,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   afull,
    output logic                   overflow,
    output logic                   bad_frame,
    input  logic                   sts_clr,
    input  logic [15:0]            cfg_timeout,
    output logic                   rx_timeout
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic drop, push, pop, full;
    logic [STS_W-1:0] sts_q, sts_d;
    assign drop       = cfg_drop_bad & parity_err;
    assign full       = level == LW'(DEPTH);
    assign dout_valid = level != '0;
    assign pop        = dout_valid & dout_ready;
    assign push       = rx_valid & ~drop & (~full | pop);
    assign afull      = level >= LW'(AFULL_LVL);
    assign overflow   = sts_q[STS_OVERFLOW];
    assign bad_frame  = sts_q[STS_BAD_FRAME];
    uart_sync_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({parity_err, rx_dout}),
        .dout  ({dout_perr, dout}),
        .level (level)
    );
    // sticky flags: a new event in the same cycle as sts_clr wins
    always_comb begin
        sts_d = sts_clr ? '0 : sts_q;
        sts_d[STS_OVERFLOW]  = sts_d[STS_OVERFLOW] | (rx_valid & ~drop & full & ~pop);
        sts_d[STS_BAD_FRAME] = sts_d[STS_BAD_FRAME] | (rx_valid & drop);
        sts_d = rst ? '0 : sts_d;
    end
    // status register
    always_ff @(posedge clk) begin
        sts_q <= sts_d;
    end
`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    assign rx_timeout = dout_valid & (cfg_timeout != '0) & (idle_q >= cfg_timeout);
    // idle counter restarts on any FIFO activity or when empty, saturates otherwise
    always_comb begin
        idle_d = (rst | push | pop | ~dout_valid) ? '0 : (&idle_q) ? idle_q : idle_q + 16'd1;
    end
    // idle counter register
    always_ff @(posedge clk) begin
        idle_q <= idle_d;
    end
`else
    logic unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
    assign rx_timeout = 1'b0;
`endif
endmodule
